// File: rtl/rfm_pkg.sv
// rfm_pkg - shared definitions for the multi-bank register file.
//
// Contents:
//   cpy_state_t   copy engine state encoding (IDLE / COPY / DONE)
//   DEF_WIDTH     default register width
//   DEF_AW        default register address width
//   DEF_NBANK     default number of banks
//   bank_bits()   width of a bank index for a given bank count
package rfm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } cpy_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AW    = 4;
  localparam int DEF_NBANK = 2;

  // Never returns less than 1, so a bank index is always a real signal.
  function automatic int bank_bits(input int nbank);
    return (nbank <= 2) ? 1 : $clog2(nbank);
  endfunction

endpackage

// File: rtl/rfm_copy_fsm.sv
// rfm_copy_fsm - background bank-copy sequencer.
//
// Walks idx from 0 to DEPTH-1, one register per cycle, and tells the
// storage which source/destination bank and address to move.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   cpy_start      one-cycle copy request (only honoured in IDLE)
//   cpy_src        source bank, latched with cpy_start
//   cpy_dst        destination bank, latched with cpy_start
//   busy           high while in COPY
//   done           high for the single DONE cycle
//   cpy_we         copy write strobe for the storage
//   cpy_addr       register being copied this cycle
//   cpy_src_bank   latched source bank
//   cpy_dst_bank   latched destination bank
module rfm_copy_fsm
  import rfm_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int BW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpy_start,
  input  logic [BW-1:0] cpy_src,
  input  logic [BW-1:0] cpy_dst,
  output logic          busy,
  output logic          done,
  output logic          cpy_we,
  output logic [AW-1:0] cpy_addr,
  output logic [BW-1:0] cpy_src_bank,
  output logic [BW-1:0] cpy_dst_bank
);

  localparam logic [AW-1:0] LAST_IDX = '1;

  cpy_state_t    state;
  logic [AW-1:0] idx;
  logic [BW-1:0] src;
  logic [BW-1:0] dst;

  // busy and done are registered alongside the state so they are glitch-free
  // and always equal (state==COPY) and (state==DONE) respectively.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      src   <= '0;
      dst   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cpy_start) begin
            src   <= cpy_src;
            dst   <= cpy_dst;
            idx   <= '0;
            busy  <= 1'b1;
            state <= COPY;
          end
        end
        COPY: begin
          // The last register is written on the same edge that leaves COPY,
          // so idx is parked at 0 instead of wrapping.
          if (idx == LAST_IDX) begin
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          idx   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign cpy_we       = busy;
  assign cpy_addr     = idx;
  assign cpy_src_bank = src;
  assign cpy_dst_bank = dst;

endmodule

// File: rtl/rfm_bank.sv
// rfm_bank - NBANK banks of 2^AW registers, WIDTH bits each.
//
// Two combinational read ports and one synchronous write port address the
// bank chosen by bsel. A background engine can copy a whole bank into
// another, one register per cycle, while the ports stay fully usable.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset (clears all banks)
//   bsel         bank used by ra/rb/rd
//   din, wen, rd write data, enable, address
//   ra, da       read port A address / data
//   rb, db       read port B address / data
//   cpy_start    one-cycle request to copy bank cpy_src into bank cpy_dst
//   cpy_src      source bank
//   cpy_dst      destination bank
//   busy         copy in progress
//   done         one-cycle pulse after the last register is copied
module rfm_bank
  import rfm_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int AW     = DEF_AW,
  parameter  int NBANK  = DEF_NBANK,
  parameter  int BYPASS = 1,
  localparam int BW     = bank_bits(NBANK)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BW-1:0]    bsel,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] da,
  input  logic [AW-1:0]    rb,
  output logic [WIDTH-1:0] db,
  input  logic             cpy_start,
  input  logic [BW-1:0]    cpy_src,
  input  logic [BW-1:0]    cpy_dst,
  output logic             busy,
  output logic             done
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [BW:0]   NBANK_L = (BW + 1)'(NBANK);

  logic [WIDTH-1:0] mem [NBANK][DEPTH];

  logic          cpy_we;
  logic [AW-1:0] cpy_addr;
  logic [BW-1:0] cpy_src_bank;
  logic [BW-1:0] cpy_dst_bank;

  logic bsel_ok;
  logic cpy_ok;

  rfm_copy_fsm #(
    .AW (AW),
    .BW (BW)
  ) u_copy (
    .clk          (clk),
    .reset        (reset),
    .cpy_start    (cpy_start),
    .cpy_src      (cpy_src),
    .cpy_dst      (cpy_dst),
    .busy         (busy),
    .done         (done),
    .cpy_we       (cpy_we),
    .cpy_addr     (cpy_addr),
    .cpy_src_bank (cpy_src_bank),
    .cpy_dst_bank (cpy_dst_bank)
  );

  // Bank indices beyond NBANK only exist when NBANK is not a power of two;
  // such accesses are dropped (writes) or read as zero.
  assign bsel_ok = ({1'b0, bsel} < NBANK_L);
  assign cpy_ok  = ({1'b0, cpy_src_bank} < NBANK_L) &&
                   ({1'b0, cpy_dst_bank} < NBANK_L);

  // Storage. The external write is issued after the copy write so that,
  // when both hit the same register on the same edge, the later
  // non-blocking assignment (the external write) is the one that sticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < DEPTH; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else begin
      if (cpy_we && cpy_ok) begin
        mem[cpy_dst_bank][cpy_addr] <= mem[cpy_src_bank][cpy_addr];
      end
      if (wen && bsel_ok) begin
        mem[bsel][rd] <= din;
      end
    end
  end

  // Read ports. The bypass forwards only the external write data; copy
  // traffic never appears here until it has landed in the array.
  always_comb begin
    da = '0;
    db = '0;
    if (bsel_ok) begin
      da = mem[bsel][ra];
      db = mem[bsel][rb];
    end
    if ((BYPASS != 0) && wen && bsel_ok) begin
      if (rd == ra) begin
        da = din;
      end
      if (rd == rb) begin
        db = din;
      end
    end
  end

endmodule

// File: tb/tb_rfm_bank.sv
// tb_rfm_bank - self-checking bench for rfm_bank.
//
// Two instances share all inputs: u_dut with the write-first bypass and
// u_nb without it. Single-cycle read/write behaviour comes from a vector
// table; copy, collision, ignored restarts and reset mid-copy are covered
// by hand-written sequences. Inputs change on the falling edge, outputs
// are sampled 1 time unit later.
module tb_rfm_bank;

  logic        clk;
  logic        reset;
  logic [0:0]  bsel;
  logic [31:0] din;
  logic        wen;
  logic [3:0]  rd;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        cpy_start;
  logic [0:0]  cpy_src;
  logic [0:0]  cpy_dst;

  logic [31:0] da;
  logic [31:0] db;
  logic        busy;
  logic        done;
  logic [31:0] da_nb;
  logic [31:0] db_nb;
  logic        busy_nb;
  logic        done_nb;

  int checks;
  int failures;

  logic [31:0] exp_mem [2][16];

  typedef struct {
    logic        bsel;
    logic        wen;
    logic [3:0]  rd;
    logic [31:0] din;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] exp_da;
    logic [31:0] exp_db;
    logic [31:0] exp_da_nb;
    logic [31:0] exp_db_nb;
  } vec_t;

  vec_t vecs [9];

  rfm_bank #(.WIDTH(32), .AW(4), .NBANK(2), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .bsel(bsel), .din(din), .wen(wen), .rd(rd),
    .ra(ra), .da(da), .rb(rb), .db(db), .cpy_start(cpy_start),
    .cpy_src(cpy_src), .cpy_dst(cpy_dst), .busy(busy), .done(done)
  );

  rfm_bank #(.WIDTH(32), .AW(4), .NBANK(2), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .bsel(bsel), .din(din), .wen(wen), .rd(rd),
    .ra(ra), .da(da_nb), .rb(rb), .db(db_nb), .cpy_start(cpy_start),
    .cpy_src(cpy_src), .cpy_dst(cpy_dst), .busy(busy_nb), .done(done_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    wen       = 1'b0;
    cpy_start = 1'b0;
    din       = '0;
    rd        = '0;
  endtask

  // One table row: drive, let the combinational paths settle, compare, clock.
  task automatic applyStimulus(input vec_t v, input int n);
    bsel = v.bsel;
    wen  = v.wen;
    rd   = v.rd;
    din  = v.din;
    ra   = v.ra;
    rb   = v.rb;
    #1;
    checkOutput($sformatf("vec%0d_da", n), da, v.exp_da);
    checkOutput($sformatf("vec%0d_db", n), db, v.exp_db);
    checkOutput($sformatf("vec%0d_da_nobypass", n), da_nb, v.exp_da_nb);
    checkOutput($sformatf("vec%0d_db_nobypass", n), db_nb, v.exp_db_nb);
    @(negedge clk);
    idleInputs();
  endtask

  // Reads every register of a bank through both ports of the bypass instance.
  task automatic checkBank(input int b, input string tag);
    idleInputs();
    bsel = 1'(b);
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i);
      rb = 4'(15 - i);
      #1;
      checkOutput($sformatf("%s_b%0d_r%0d", tag, b, i), da, exp_mem[b][i]);
      checkOutput($sformatf("%s_b%0d_r%0d_portb", tag, b, 15 - i), db,
                  exp_mem[b][15 - i]);
    end
  endtask

  task automatic writeReg(input int b, input int a, input logic [31:0] value);
    bsel = 1'(b);
    rd   = 4'(a);
    din  = value;
    wen  = 1'b1;
    @(negedge clk);
    idleInputs();
    exp_mem[b][a] = value;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++)
        exp_mem[b][i] = '0;
  endtask

  // Starts a copy and watches 20 cycles. With actions set, external writes
  // and a stray cpy_start are injected at chosen idx values. A cpy_start is
  // always attempted during the DONE cycle, where it must be ignored too.
  task automatic runCopy(input int src, input int dst, input bit actions,
                         input string tag);
    int busy_cycles;
    int done_pulses;
    int first_busy;
    int done_at;
    busy_cycles = 0;
    done_pulses = 0;
    first_busy  = -1;
    done_at     = -1;
    idleInputs();
    cpy_src   = 1'(src);
    cpy_dst   = 1'(dst);
    cpy_start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      idleInputs();
      #1;
      if (busy) begin
        busy_cycles++;
        if (first_busy < 0) first_busy = c;
      end
      if (done) begin
        done_pulses++;
        done_at   = c;
        cpy_start = 1'b1;
        cpy_src   = 1'(dst);
        cpy_dst   = 1'(src);
      end
      if (actions) begin
        case (c)
          3: begin bsel = 1'(src); rd = 4'd12; din = 32'h5A5A_5A5A; wen = 1'b1; end
          5: begin cpy_start = 1'b1; cpy_src = 1'(dst); cpy_dst = 1'(src); end
          7: begin bsel = 1'(dst); rd = 4'd7; din = 32'hAAAA_5555; wen = 1'b1; end
          10: begin bsel = 1'(src); rd = 4'd2; din = 32'h7777_7777; wen = 1'b1; end
          default: ;
        endcase
      end
      @(negedge clk);
    end
    idleInputs();
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
    checkOutput({tag, "_first_busy"}, 32'(first_busy), 32'd0);
    checkOutput({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
    checkOutput({tag, "_done_at"}, 32'(done_at), 32'd16);
  endtask

  initial begin
    int stray;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bsel      = '0;
    ra        = '0;
    rb        = '0;
    cpy_src   = '0;
    cpy_dst   = '0;
    idleInputs();

    vecs[0] = '{1'b0, 1'b1, 4'd5,  32'h1234_5678, 4'd5,  4'd0,
                32'h1234_5678, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd5,  4'd5,
                32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 4'd5,  32'hCAFE_F00D, 4'd5,  4'd3,
                32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 4'd3,  32'h0000_0003, 4'd5,  4'd3,
                32'h1234_5678, 32'h0000_0003, 32'h1234_5678, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 4'd0,  32'h0,         4'd5,  4'd3,
                32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 4'd5,  32'hFFFF_FFFF, 4'd5,  4'd5,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
    vecs[6] = '{1'b0, 1'b0, 4'd0,  32'h0,         4'd5,  4'd3,
                32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[7] = '{1'b1, 1'b1, 4'd15, 32'h8000_0001, 4'd15, 4'd0,
                32'h8000_0001, 32'h0, 32'h0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 4'd0,  32'h0,         4'd15, 4'd5,
                32'h8000_0001, 32'hCAFE_F00D, 32'h8000_0001, 32'hCAFE_F00D};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset clears a previously written register and the copy status.
    writeReg(1, 3, 32'hDEAD_BEEF);
    bsel = 1'b1;
    ra   = 4'd3;
    #1;
    checkOutput("prereset_b1_r3", da, 32'hDEAD_BEEF);
    pulseReset();
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkBank(0, "reset");
    checkBank(1, "reset");

    // Single-cycle write/read/bypass table.
    @(negedge clk);
    for (int n = 0; n < 9; n++) begin
      applyStimulus(vecs[n], n);
    end

    // Copy bank0 -> bank1 with a collision, source writes on both sides of
    // idx, and a stray start request while busy.
    pulseReset();
    for (int i = 0; i < 16; i++) begin
      writeReg(0, i, 32'h100 + 32'(i));
    end
    for (int i = 0; i < 16; i++) begin
      exp_mem[1][i] = 32'h100 + 32'(i);
    end
    runCopy(0, 1, 1'b1, "copy01");
    exp_mem[0][12] = 32'h5A5A_5A5A;
    exp_mem[1][12] = 32'h5A5A_5A5A;
    exp_mem[0][2]  = 32'h7777_7777;
    exp_mem[1][7]  = 32'hAAAA_5555;
    checkBank(0, "copy01");
    checkBank(1, "copy01");

    // Copying a bank onto itself runs the full sequence and changes nothing.
    runCopy(1, 1, 1'b0, "copy11");
    checkBank(1, "copy11");
    checkBank(0, "copy11");

    // Reset at idx=4: status drops at once, no late done, banks cleared.
    idleInputs();
    cpy_src   = 1'b0;
    cpy_dst   = 1'b1;
    cpy_start = 1'b1;
    @(negedge clk);
    cpy_start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("midreset_busy_before", 32'(busy), 32'd1);
    pulseReset();
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy || done) stray++;
      @(negedge clk);
    end
    checkOutput("midreset_stray_status", 32'(stray), 32'd0);
    checkBank(0, "midreset");
    checkBank(1, "midreset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/rfm_bank.md
# rfm_bank

Parametrised, multi-bank successor of the 16×32 register file. It provides NBANK banks of 2^AW registers, each WIDTH bits wide. Each bank has two combinational read ports, one synchronous write port, an optional write-first bypass, and a background bank-copy engine that moves one register per cycle. It sits in the CPU datapath in place of the single-bank file and supports fast context switching (interrupt or shadow bank).

## Interface
- WIDTH, 32, register width in bits
- AW, 4, register address width; DEPTH = 2^AW
- NBANK, 2, number of banks; must be ≥2; BW = $clog2(NBANK)
- BYPASS, 1, 1: read ports return din when reading the register being written this cycle; 0: read ports return stored value
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- bsel  in  BW  bank used by ra/rb/rd accesses
- din  in  WIDTH  write data
- wen  in  1  write enable
- rd  in  AW  write address
- ra  in  AW  read address A
- da  out  WIDTH  read data A (combinational)
- rb  in  AW  read address B
- db  out  WIDTH  read data B (combinational)
- cpy_start  in  1  one-cycle request to copy bank cpy_src into bank cpy_dst
- cpy_src  in  BW  source bank, sampled with cpy_start
- cpy_dst  in  BW  destination bank, sampled with cpy_start
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse after the last register is copied

## Operation
- Reset (edge with reset=1): all NBANK×DEPTH registers are set to 0, FSM goes to IDLE, idx=0, busy=0, done=0. Reset overrides wen and any copy in progress.
- Write: at the edge, if wen=1, bank[bsel][rd] <= din.
- Read: da = bank[bsel][ra]; db = bank[bsel][rb].
  - With BYPASS=1 and wen=1, rd==ra gives da=din (same for rb/db).
  - With BYPASS=0, the old value is shown until the edge.
- Copy FSM states: IDLE, COPY, DONE.
  - IDLE: if cpy_start=1, latch src/dst, set idx=0, go to COPY.
  - COPY: each edge writes bank[dst][idx] <= bank[src][idx] and increments idx. At idx=DEPTH-1 the FSM writes the last register and goes to DONE.
  - DONE: one cycle, then IDLE. done=1 only in DONE.
- busy = (state==COPY).
- cpy_start is ignored in COPY and DONE. It is not queued.
- Collision rule: if wen targets bank dst at address idx in the same edge as the copy write, the external write wins and the copy value is dropped.
  - External writes to any other location proceed normally during a copy.
  - An external write to bank[src][j] with j>idx is visible in the copied result. With j<idx it is not.
- cpy_src == cpy_dst: the FSM runs the full sequence; the data is unchanged.
- Read ports never stall and never see copy data through the bypass. The bypass applies only to the external write.
- idx is AW bits wide and never wraps inside COPY.

## Timing
- Read latency is 0 (combinational).
- Write latency is 1 edge.
- cpy_start high at edge k: busy=1 in cycles k+1…k+DEPTH, done=1 in cycle k+DEPTH+1, idle again from k+DEPTH+2.
  - A new cpy_start is accepted at edge k+DEPTH+2 at the earliest.
- Register j of dst holds the copied value after edge k+1+j.
- Reset mid-copy: from the next cycle busy=0, done=0, all banks are 0, and no done pulse is produced.

## Structure
- rfm_pkg holds:
  - the FSM state enum (IDLE/COPY/DONE)
  - default WIDTH/AW/NBANK localparams
  - a bank-index width function
- One sub-module, rfm_copy_fsm. It contains the state register, idx counter, src/dst latches and busy/done, and outputs the copy write enable, address and banks.
- Storage, the write mux with its collision priority, and the read/bypass logic stay in rfm_bank.

## Test plan
- Reset: write 0xDEADBEEF to bank1 r3, then assert reset for 1 cycle → all da/db reads return 0 in both banks; busy=0, done=0.
- Write/read/bypass: bsel=0, wen=1, rd=5, din=0x12345678, ra=5 → da=0x12345678 in the same cycle (BYPASS=1). With BYPASS=0, da=0 in that cycle and 0x12345678 after the edge.
- Copy: fill bank0 with r[i]=0x100+i, start copy 0→1 → busy for exactly 16 cycles, then a one-cycle done; bank1 r[i]=0x100+i for all i; bank0 unchanged.
- Collision: during the copy, at the cycle where idx=7, write bank1 r7=0xAAAA5555 → bank1 r7=0xAAAA5555 and all other bank1 registers equal the copied values.
- Start while busy: pulse cpy_start (1→0) mid-copy → ignored; only one done pulse; busy remains 16 cycles total.
- Reset mid-copy: assert reset at idx=4 → busy and done drop, all registers are 0, and no done pulse follows.
